mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 39 +++
 rtl/mult_div_datapath.sv | 103 ++++++++++
 rtl/mult_div_unit.sv | 113 +++++++++++
 tb/tb_mult_div_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared processor definitions: ALU operation codes, mult/div operation encodings,
// mult/div FSM state encodings and small helpers used by the mult/div unit.
package mult_div_unit_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

endpackage

// File: rtl/mult_div_datapath.sv
// Iterative multiply/divide datapath: 64-bit working register, iteration counter
// and final sign correction of the magnitude result.
module mult_div_datapath
    import mult_div_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        last_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] work_q, work_d;
    logic [4:0]  cnt_q, cnt_d;

    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic [32:0] trial;
    logic [32:0] sum;
    logic [63:0] prod;
    logic [31:0] quot, rem;

    always_comb begin
        sign_a = md_is_signed(op_i) & a_i[31];
        sign_b = md_is_signed(op_i) & b_i[31];
        mag_a  = sign_a ? neg32(a_i) : a_i;
        mag_b  = sign_b ? neg32(b_i) : b_i;
        // Restoring divide: shift left one bit and try to subtract the divisor.
        trial  = work_q[63:31] - {1'b0, opnd_q};
        // Shift-add multiply: add multiplicand to the upper half when LSB is set.
        sum    = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);

        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        opnd_d    = opnd_q;
        work_d    = work_q;
        cnt_d     = cnt_q;

        if (load_i) begin
            is_div_d  = md_is_div(op_i);
            neg_d     = sign_a ^ sign_b;
            rem_neg_d = sign_a;
            cnt_d     = 5'd31;
            if (md_is_div(op_i)) begin
                work_d = {32'd0, mag_a};
                opnd_d = mag_b;
            end else begin
                work_d = {32'd0, mag_b};
                opnd_d = mag_a;
            end
        end else if (step_i) begin
            cnt_d = cnt_q - 5'd1;
            if (is_div_q) begin
                if (!trial[32]) begin
                    work_d = {trial[31:0], work_q[30:0], 1'b1};
                end else begin
                    work_d = {work_q[62:0], 1'b0};
                end
            end else begin
                work_d = {sum, work_q[31:1]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            opnd_q    <= 32'd0;
            work_q    <= 64'd0;
            cnt_q     <= 5'd0;
        end else begin
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            opnd_q    <= opnd_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        prod = neg_q ? neg64(work_q) : work_q;
        quot = neg_q ? neg32(work_q[31:0]) : work_q[31:0];
        rem  = rem_neg_q ? neg32(work_q[63:32]) : work_q[63:32];
        hi_o = is_div_q ? rem : prod[63:32];
        lo_o = is_div_q ? quot : prod[31:0];
    end

    assign last_o = (cnt_q == 5'd0);

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and
// MTHI/MTLO direct writes; control FSM here, iteration in mult_div_datapath.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  MDOperation,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MTHI,
    input  logic        MTLO,
    input  logic [31:0] WriteData,
    output logic        Busy,
    output logic        Done,
    output logic        DivByZero,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic [1:0]  state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;
    logic        zero_q, zero_d;

    logic        dp_load, dp_step, dp_last;
    logic [31:0] dp_hi, dp_lo;

    mult_div_datapath u_datapath (
        .clk_i  (clk),
        .rst_ni (reset),
        .load_i (dp_load),
        .step_i (dp_step),
        .op_i   (MDOperation),
        .a_i    (A),
        .b_i    (B),
        .last_o (dp_last),
        .hi_o   (dp_hi),
        .lo_o   (dp_lo)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
        zero_d  = zero_q;
        dp_load = 1'b0;
        dp_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dp_load = 1'b1;
                    // A zero divisor bypasses the iterations entirely.
                    if (md_is_div(MDOperation) && (B == 32'd0)) begin
                        zero_d  = 1'b1;
                        state_d = ST_FIX;
                    end else begin
                        zero_d  = 1'b0;
                        state_d = ST_CALC;
                    end
                end else begin
                    if (MTHI) hi_d = WriteData;
                    if (MTLO) lo_d = WriteData;
                end
            end
            ST_CALC: begin
                dp_step = 1'b1;
                if (dp_last) state_d = ST_FIX;
            end
            ST_FIX: begin
                done_d  = 1'b1;
                dbz_d   = zero_q;
                state_d = ST_IDLE;
                if (!zero_q) begin
                    hi_d = dp_hi;
                    lo_d = dp_lo;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            zero_q  <= zero_d;
        end
    end

    assign Busy      = (state_q != ST_IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected results, a monitor
// pops and compares them whenever Done is presented.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  MDOperation = 2'b00;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        MTHI = 1'b0;
    logic        MTLO = 1'b0;
    logic [31:0] WriteData = 32'd0;
    logic        Busy, Done, DivByZero;
    logic [31:0] HI, LO;

    mult_div_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .MDOperation (MDOperation),
        .A           (A),
        .B           (B),
        .MTHI        (MTHI),
        .MTLO        (MTLO),
        .WriteData   (WriteData),
        .Busy        (Busy),
        .Done        (Done),
        .DivByZero   (DivByZero),
        .HI          (HI),
        .LO          (LO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
        int          issue;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // Monitor: every Done must match the oldest expected result and last one cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && Done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {63'd0, Done}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_hi"}, {32'd0, HI}, {32'd0, e.hi});
                    check({e.name, "_lo"}, {32'd0, LO}, {32'd0, e.lo});
                    check({e.name, "_dbz"}, {63'd0, DivByZero}, {63'd0, e.dbz});
                    check({e.name, "_lat"}, 64'(cyc - e.issue + 1), 64'(e.lat));
                    @(negedge clk);
                    check({e.name, "_pulse"}, {63'd0, Done}, 64'd0);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic mthi, input logic mtlo, input logic [31:0] wd,
                         input logic [31:0] eh, input logic [31:0] el, input logic ez,
                         input int lat, input string nm);
        exp_t e;
        @(posedge clk); #1;
        MDOperation = op; A = a; B = b; start = 1'b1;
        MTHI = mthi; MTLO = mtlo; WriteData = wd;
        e.name = nm; e.hi = eh; e.lo = el; e.dbz = ez; e.lat = lat; e.issue = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
        check({nm, "_busy"}, {63'd0, Busy}, 64'd1);
    endtask

    task automatic wait_done(input string nm);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        if (k == 100) begin
            check({nm, "_timeout"}, 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(posedge clk);
    endtask

    task automatic mt_write(input logic hi_en, input logic lo_en, input logic [31:0] wd);
        @(posedge clk); #1;
        MTHI = hi_en; MTLO = lo_en; WriteData = wd;
        @(posedge clk); #1;
        MTHI = 1'b0; MTLO = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_dbz", {63'd0, DivByZero}, 64'd0);
        check("rst_hi", {32'd0, HI}, 64'd0);
        check("rst_lo", {32'd0, LO}, 64'd0);
        @(posedge clk); #1 reset = 1'b1;

        // Signed multiply; junk start/MTLO/operand changes while busy must be ignored
        issue(2'b00, 32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b0, 32'd0,
              32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34, "mult_neg");
        A = 32'h0; B = 32'h0; MDOperation = 2'b11; start = 1'b1; MTLO = 1'b1;
        WriteData = 32'hBAD0BAD0;
        @(posedge clk); #1;
        start = 1'b0; MTLO = 1'b0;
        A = 32'h12345678; B = 32'h9ABCDEF0;
        wait_done("mult_neg");

        issue(2'b01, 32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b0, 32'd0,
              32'h00000001, 32'hFFFFFFFE, 1'b0, 34, "multu");
        wait_done("multu");

        issue(2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0, 32'd0,
              32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, "div_neg");
        wait_done("div_neg");

        issue(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0,
              32'h00000002, 32'h0000000E, 1'b0, 34, "divu");
        wait_done("divu");

        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0,
              32'h00000000, 32'h80000000, 1'b0, 34, "div_ovf");
        wait_done("div_ovf");

        // Direct writes
        mt_write(1'b1, 1'b1, 32'h00000055);
        check("mt_both_hi", {32'd0, HI}, 64'h55);
        check("mt_both_lo", {32'd0, LO}, 64'h55);
        mt_write(1'b1, 1'b0, 32'h00001234);
        check("mthi_hi", {32'd0, HI}, 64'h1234);
        check("mthi_lo", {32'd0, LO}, 64'h55);

        issue(2'b11, 32'd9, 32'd0, 1'b0, 1'b0, 32'd0,
              32'h00001234, 32'h00000055, 1'b1, 2, "divu_zero");
        wait_done("divu_zero");

        // start wins over a same-cycle MTHI
        issue(2'b01, 32'd3, 32'd5, 1'b1, 1'b0, 32'hDEADBEEF,
              32'h00000000, 32'h0000000F, 1'b0, 34, "start_vs_mthi");
        wait_done("start_vs_mthi");

        // Reset mid-operation aborts with no Done
        @(posedge clk); #1;
        MDOperation = 2'b00; A = 32'd7; B = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mt_write(1'b0, 1'b1, 32'h0000AAAA);
        check("mtlo_busy_lo", {32'd0, LO}, 64'hF);
        @(posedge clk); #1;
        MDOperation = 2'b11; A = 32'd1; B = 32'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, Busy}, 64'd0);
        check("abort_hi", {32'd0, HI}, 64'd0);
        check("abort_lo", {32'd0, LO}, 64'd0);
        check("abort_done", {63'd0, Done}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (40) @(posedge clk);
        #1 check("after_abort_busy", {63'd0, Busy}, 64'd0);

        issue(2'b00, 32'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0,
              32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, "mult_after_rst");
        wait_done("mult_after_rst");

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
